// File: rtl/csa12_pkg.sv
// Shared types for the 12-bit limb-streaming adder pipeline.
// The core width is fixed by the carry-select adder.
package csa12_pkg;

  localparam int CORE_W = 12;

  typedef struct packed {
    logic [CORE_W-1:0] x;
    logic [CORE_W-1:0] y;
    logic              first;
    logic              last;
  } limb_beat_t;

endpackage

// File: rtl/csa12_carry_inc.sv
// Adds the chained carry to the core sum; output is {carry, limb}.
// Width leaves headroom: 4095+4095+1 never overflows 13 bits.
module csa12_carry_inc #(
  parameter int W = 13
) (
  input  logic [W-1:0] i_a,
  input  logic         i_cin,
  output logic [W-1:0] o_t
);

  assign o_t = i_a + {{(W-1){1'b0}}, i_cin};

endmodule

// File: rtl/csa12_csel_adder.sv
// Combinational 12-bit carry-select adder core, carry-in tied 0.
// Three 4-bit blocks; upper blocks precompute both carry cases.
module csa12_csel_adder (
  input  logic [11:0] i_a,
  input  logic [11:0] i_b,
  output logic [12:0] o_s
);

  logic [4:0] w_lo;
  logic [4:0] w_mid0;
  logic [4:0] w_mid1;
  logic [4:0] w_mid;
  logic [4:0] w_hi0;
  logic [4:0] w_hi1;
  logic [4:0] w_hi;

  assign w_lo   = {1'b0, i_a[3:0]} + {1'b0, i_b[3:0]};
  assign w_mid0 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]};
  assign w_mid1 = {1'b0, i_a[7:4]} + {1'b0, i_b[7:4]} + 5'd1;
  assign w_hi0  = {1'b0, i_a[11:8]} + {1'b0, i_b[11:8]};
  assign w_hi1  = {1'b0, i_a[11:8]} + {1'b0, i_b[11:8]} + 5'd1;

  assign w_mid  = w_lo[4]  ? w_mid1 : w_mid0;
  assign w_hi   = w_mid[4] ? w_hi1  : w_hi0;

  assign o_s = {w_hi, w_mid[3:0], w_lo[3:0]};

endmodule

// File: rtl/csa12_limb_pipe.sv
// Two-stage valid/ready pipeline streaming multi-limb adds, LSB limb first.
// S1 registers operands; S2 adds, chains carry and tracks limb index.
module csa12_limb_pipe
  import csa12_pkg::*;
#(
  parameter int LIMB_W = 12,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LIMB_W-1:0] in_x,
  input  logic [LIMB_W-1:0] in_y,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LIMB_W-1:0] out_sum,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_cout
);

  if (LIMB_W != CORE_W) begin : g_bad_width
    $error("csa12_limb_pipe: LIMB_W must equal the adder core width");
  end

  logic              r_s1_v;
  limb_beat_t        r_s1;
  logic              r_s2_v;
  logic [LIMB_W-1:0] r_sum;
  logic [IDX_W-1:0]  r_idx;
  logic              r_last;
  logic              r_cout;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx_q;

  logic              w_s2_adv;
  logic              w_s1_load;
  logic              w_s2_load;
  logic              w_cin;
  logic [LIMB_W:0]   w_sum13;
  logic [LIMB_W:0]   w_t;

  assign w_s2_adv  = !r_s2_v | out_ready;
  assign in_ready  = !r_s1_v | w_s2_adv;
  assign w_s1_load = in_valid & in_ready;
  assign w_s2_load = r_s1_v & w_s2_adv;
  assign w_cin     = r_s1.first ? 1'b0 : r_carry;

  csa12_csel_adder u_core (
    .i_a (r_s1.x),
    .i_b (r_s1.y),
    .o_s (w_sum13)
  );

  csa12_carry_inc #(.W(LIMB_W + 1)) u_inc (
    .i_a   (w_sum13),
    .i_cin (w_cin),
    .o_t   (w_t)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1   <= '0;
    end else if (w_s1_load) begin
      r_s1_v <= 1'b1;
      r_s1   <= '{x: in_x, y: in_y, first: in_first, last: in_last};
    end else if (w_s2_load) begin
      r_s1_v <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v  <= 1'b0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx_q <= '0;
    end else if (w_s2_load) begin
      r_s2_v  <= 1'b1;
      r_sum   <= w_t[LIMB_W-1:0];
      r_last  <= r_s1.last;
      r_carry <= r_s1.last ? 1'b0 : w_t[LIMB_W];
      r_cout  <= r_s1.last ? w_t[LIMB_W] : 1'b0;
      r_idx   <= r_s1.first ? '0 : r_idx_q;
      // A new first restarts numbering even if the prior packet never ended
      if (r_s1.last)
        r_idx_q <= '0;
      else if (r_s1.first)
        r_idx_q <= IDX_W'(1);
      else
        r_idx_q <= r_idx_q + IDX_W'(1);
    end else if (out_ready) begin
      r_s2_v  <= 1'b0;
    end
  end

  assign out_valid = r_s2_v;
  assign out_sum   = r_sum;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign out_cout  = r_cout;

endmodule
